// File: rtl/riscv_data_memory_mmio_pkg.sv
// Shared constants for the data memory: MMIO register offsets and the address-decode result type.
// The access-counter offsets only decode when RISCV_DMEM_ACCESS_COUNTERS_EN is defined.
package riscv_data_memory_mmio_pkg;

  localparam logic [31:0] MMIO_OFF_TOHOST   = 32'h0000_0000;
  localparam logic [31:0] MMIO_OFF_CYCLE_LO = 32'h0000_0004;
  localparam logic [31:0] MMIO_OFF_CYCLE_HI = 32'h0000_0008;
  localparam logic [31:0] MMIO_OFF_LOADCNT  = 32'h0000_000C;
  localparam logic [31:0] MMIO_OFF_STORECNT = 32'h0000_0010;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_TOHOST,
    DEC_CYCLE_LO,
    DEC_CYCLE_HI,
    DEC_LOADCNT,
    DEC_STORECNT,
    DEC_UNMAPPED
  } dmem_region_e;

endpackage

// File: rtl/riscv_data_memory_mmio_if.sv
// Memory-stage bus between the datapath (master) and the data memory (slave).
// Read data is combinational from the slave in the same cycle as the request.
interface riscv_data_memory_mmio_if;

  logic [31:0] memoryAddress;
  logic        memoryReadEnable;
  logic        memoryWriteEnable;
  logic [31:0] memoryWriteData;
  logic [31:0] memoryReadData;

  modport master (
    output memoryAddress, memoryReadEnable, memoryWriteEnable, memoryWriteData,
    input  memoryReadData
  );

  modport slave (
    input  memoryAddress, memoryReadEnable, memoryWriteEnable, memoryWriteData,
    output memoryReadData
  );

endinterface

// File: rtl/riscv_data_memory_mmio_addr_decode.sv
// Combinational byte-address decoder shared by data-memory style windows.
// Counter registers decode only with RISCV_DMEM_ACCESS_COUNTERS_EN defined; otherwise they are unmapped.
module riscv_dmem_addr_decode
  import riscv_data_memory_mmio_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic [31:0]  addr,
  output dmem_region_e region,
  output logic         aligned
);

  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] mmio_off;

  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    mmio_off = addr - MMIO_BASE;
    region   = DEC_UNMAPPED;
    if (addr < RAM_BYTES) begin
      region = DEC_RAM;
    end else begin
      case (mmio_off)
        MMIO_OFF_TOHOST:   region = DEC_TOHOST;
        MMIO_OFF_CYCLE_LO: region = DEC_CYCLE_LO;
        MMIO_OFF_CYCLE_HI: region = DEC_CYCLE_HI;
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
        MMIO_OFF_LOADCNT:  region = DEC_LOADCNT;
        MMIO_OFF_STORECNT: region = DEC_STORECNT;
`endif
        default:           region = DEC_UNMAPPED;
      endcase
    end
  end

endmodule

// File: rtl/riscv_data_memory_mmio.sv
// Word-addressed data RAM plus tohost/cycle MMIO window with sticky halt and fault capture.
// Optional load/store access counters are enabled by defining RISCV_DMEM_ACCESS_COUNTERS_EN.
module riscv_data_memory_mmio
  import riscv_data_memory_mmio_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  riscv_data_memory_mmio_if.slave bus,
  output logic [31:0]             tohostValue,
  output logic                    halted,
  output logic                    accessFault,
  output logic [31:0]             faultAddress
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmem_region_e     region;
  logic             aligned;
  logic [IDX_W-1:0] ram_idx;
  logic             access_ok, fault, read_ok, write_ok;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0] tohost_q, tohost_d, fault_addr_q, fault_addr_d;
  logic        halted_q, halted_d, fault_q, fault_d;
  logic [63:0] cycle_q, cycle_d;
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
  logic [31:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;
`endif

  riscv_dmem_addr_decode #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MMIO_BASE   (MMIO_BASE)
  ) u_decode (
    .addr    (bus.memoryAddress),
    .region  (region),
    .aligned (aligned)
  );

  assign ram_idx   = bus.memoryAddress[IDX_W+1:2];
  assign access_ok = aligned && (region != DEC_UNMAPPED);
  assign fault     = (bus.memoryReadEnable || bus.memoryWriteEnable) && !access_ok;
  assign read_ok   = bus.memoryReadEnable && access_ok;
  // Read-only registers swallow stores silently, so only RAM and tohost are writable targets.
  assign write_ok  = bus.memoryWriteEnable && access_ok && !halted_q && !rst &&
                     ((region == DEC_RAM) || (region == DEC_TOHOST));

  // MMIO reads show reset values while rst is held, even before the first reset edge.
  always_comb begin
    bus.memoryReadData = 32'h0;
    if (read_ok) begin
      case (region)
        DEC_RAM:      bus.memoryReadData = mem[ram_idx];
        DEC_TOHOST:   bus.memoryReadData = rst ? 32'h0 : tohost_q;
        DEC_CYCLE_LO: bus.memoryReadData = rst ? 32'h0 : cycle_q[31:0];
        DEC_CYCLE_HI: bus.memoryReadData = rst ? 32'h0 : cycle_q[63:32];
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
        DEC_LOADCNT:  bus.memoryReadData = rst ? 32'h0 : load_cnt_q;
        DEC_STORECNT: bus.memoryReadData = rst ? 32'h0 : store_cnt_q;
`endif
        default:      bus.memoryReadData = 32'h0;
      endcase
    end
  end

  always_comb begin
    tohost_d     = tohost_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    cycle_d      = halted_q ? cycle_q : cycle_q + 64'd1;
    if (write_ok && (region == DEC_TOHOST)) begin
      tohost_d = bus.memoryWriteData;
      if (bus.memoryWriteData != 32'h0) halted_d = 1'b1;
    end
    if (fault) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = bus.memoryAddress;
    end
  end

`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (read_ok && !halted_q) load_cnt_d = load_cnt_q + 32'd1;
    if (write_ok) store_cnt_d = store_cnt_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_q     <= 32'h0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      cycle_q      <= 64'h0;
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
      load_cnt_q   <= 32'h0;
      store_cnt_q  <= 32'h0;
`endif
    end else begin
      tohost_q     <= tohost_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      cycle_q      <= cycle_d;
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
`endif
    end
  end

  // RAM contents survive reset; write_ok already excludes rst and halt.
  always_ff @(posedge clk) begin
    if (write_ok && (region == DEC_RAM)) mem[ram_idx] <= bus.memoryWriteData;
  end

  assign tohostValue  = tohost_q;
  assign halted       = halted_q;
  assign accessFault  = fault_q;
  assign faultAddress = fault_addr_q;

endmodule

// File: tb/tb_riscv_data_memory_mmio.sv
// Directed self-checking bench for riscv_data_memory_mmio (default build or RISCV_DMEM_ACCESS_COUNTERS_EN).
// Inputs change on the falling edge; combinational read data is sampled 1ns later, state after the rising edge.
module tb_riscv_data_memory_mmio;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] tohostValue;
  logic        halted;
  logic        accessFault;
  logic [31:0] faultAddress;
  int          checks;
  int          failures;

  riscv_data_memory_mmio_if bus ();

  riscv_data_memory_mmio #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tohostValue  (tohostValue),
    .halted       (halted),
    .accessFault  (accessFault),
    .faultAddress (faultAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.memoryAddress     = a;
    bus.memoryWriteData   = d;
    bus.memoryWriteEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.memoryWriteEnable = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bus.memoryAddress    = a;
    bus.memoryReadEnable = 1'b1;
    #1;
    d = bus.memoryReadData;
    @(posedge clk);
    @(negedge clk);
    bus.memoryReadEnable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tohostValue !== 32'h0) begin failures++; $display("[TB] FAIL reset_tohost actual=%h expected=0", tohostValue); end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted actual=%b expected=0", halted); end
    checks++;
    if (accessFault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault actual=%b expected=0", accessFault); end
    checks++;
    if (faultAddress !== 32'h0) begin failures++; $display("[TB] FAIL reset_fault_addr actual=%h expected=0", faultAddress); end
    rst = 1'b0;
  endtask

  task automatic test_ram_rw();
    logic [31:0] d;
    do_write(32'h10, 32'hDEAD_BEEF);
    do_write(32'h14, 32'h1234_5678);
    do_write(32'hFFC, 32'hCAFE_F00D);
    do_read(32'h10, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL ram_read_10 actual=%h expected=deadbeef", d); end
    do_read(32'h14, d);
    checks++;
    if (d !== 32'h1234_5678) begin failures++; $display("[TB] FAIL ram_read_14 actual=%h expected=12345678", d); end
    do_read(32'hFFC, d);
    checks++;
    if (d !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL ram_read_last actual=%h expected=cafef00d", d); end
    bus.memoryAddress = 32'h10;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0) begin failures++; $display("[TB] FAIL ram_read_disabled actual=%h expected=0", bus.memoryReadData); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    do_write(32'h20, 32'h11);
    bus.memoryAddress     = 32'h20;
    bus.memoryWriteData   = 32'h22;
    bus.memoryReadEnable  = 1'b1;
    bus.memoryWriteEnable = 1'b1;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h11) begin failures++; $display("[TB] FAIL same_cycle_old actual=%h expected=11", bus.memoryReadData); end
    @(posedge clk);
    @(negedge clk);
    bus.memoryReadEnable  = 1'b0;
    bus.memoryWriteEnable = 1'b0;
    do_read(32'h20, d);
    checks++;
    if (d !== 32'h22) begin failures++; $display("[TB] FAIL same_cycle_new actual=%h expected=22", d); end
  endtask

  task automatic test_fault();
    logic [31:0] d;
    do_read(32'h6, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL misaligned_read actual=%h expected=0", d); end
    checks++;
    if (accessFault !== 1'b1) begin failures++; $display("[TB] FAIL fault_set actual=%b expected=1", accessFault); end
    checks++;
    if (faultAddress !== 32'h6) begin failures++; $display("[TB] FAIL fault_addr_first actual=%h expected=6", faultAddress); end
    do_read(MMIO_BASE + 32'h40, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_read actual=%h expected=0", d); end
    checks++;
    if (faultAddress !== 32'h6) begin failures++; $display("[TB] FAIL fault_addr_sticky actual=%h expected=6", faultAddress); end
    do_read(32'h1000, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL past_ram_read actual=%h expected=0", d); end
    do_write(32'h22, 32'hFF);
    do_read(32'h20, d);
    checks++;
    if (d !== 32'h22) begin failures++; $display("[TB] FAIL misaligned_write_dropped actual=%h expected=22", d); end
    checks++;
    if (accessFault !== 1'b1) begin failures++; $display("[TB] FAIL fault_still_set actual=%b expected=1", accessFault); end
  endtask

  task automatic test_cycle_counter();
    rst = 1'b1;
    bus.memoryAddress    = MMIO_BASE + 32'h4;
    bus.memoryReadEnable = 1'b1;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0) begin failures++; $display("[TB] FAIL cycle_read_in_reset actual=%h expected=0", bus.memoryReadData); end
    bus.memoryReadEnable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    bus.memoryAddress    = MMIO_BASE + 32'h4;
    bus.memoryReadEnable = 1'b1;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'd100) begin failures++; $display("[TB] FAIL cycle_lo_100 actual=%0d expected=100", bus.memoryReadData); end
    bus.memoryAddress = MMIO_BASE + 32'h8;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0) begin failures++; $display("[TB] FAIL cycle_hi_zero actual=%h expected=0", bus.memoryReadData); end
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    bus.memoryAddress = MMIO_BASE + 32'h4;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL cycle_lo_preload actual=%h expected=ffffffff", bus.memoryReadData); end
    checks++;
    if (dut.cycle_d !== 64'h0000_0001_0000_0000) begin failures++; $display("[TB] FAIL cycle_carry actual=%h expected=0000000100000000", dut.cycle_d); end
    release dut.cycle_q;
    bus.memoryReadEnable = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] d;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_write(32'h0, 32'h0000_A5A5);
    do_write(MMIO_BASE + 32'h4, 32'hFFFF);
    checks++;
    if (accessFault !== 1'b0) begin failures++; $display("[TB] FAIL ro_write_no_fault actual=%b expected=0", accessFault); end
    do_write(MMIO_BASE, 32'h0);
    checks++;
    if (halted !== 1'b0) begin failures++; $display("[TB] FAIL zero_tohost_no_halt actual=%b expected=0", halted); end
    do_write(MMIO_BASE, 32'h1);
    checks++;
    if (tohostValue !== 32'h1) begin failures++; $display("[TB] FAIL tohost_value actual=%h expected=1", tohostValue); end
    checks++;
    if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halted_set actual=%b expected=1", halted); end
    do_write(32'h0, 32'h55);
    do_write(MMIO_BASE, 32'h7);
    do_read(32'h0, d);
    checks++;
    if (d !== 32'h0000_A5A5) begin failures++; $display("[TB] FAIL halted_ram_write_ignored actual=%h expected=0000a5a5", d); end
    checks++;
    if (tohostValue !== 32'h1) begin failures++; $display("[TB] FAIL halted_tohost_ignored actual=%h expected=1", tohostValue); end
    do_read(MMIO_BASE + 32'h4, d);
    checks++;
    if (d !== 32'd4) begin failures++; $display("[TB] FAIL cycle_frozen actual=%0d expected=4", d); end
    do_read(MMIO_BASE, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("[TB] FAIL tohost_read actual=%h expected=1", d); end
  endtask

  task automatic test_access_counters();
    logic [31:0] d;
    rst = 1'b1;
    bus.memoryAddress    = 32'h0;
    bus.memoryReadEnable = 1'b1;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0000_A5A5) begin failures++; $display("[TB] FAIL ram_read_in_reset actual=%h expected=0000a5a5", bus.memoryReadData); end
    bus.memoryAddress = MMIO_BASE;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0) begin failures++; $display("[TB] FAIL tohost_read_in_reset actual=%h expected=0", bus.memoryReadData); end
    bus.memoryReadEnable = 1'b0;
    do_write(32'h0, 32'h77);
    rst = 1'b0;
    checks++;
    if (halted !== 1'b0) begin failures++; $display("[TB] FAIL halted_cleared actual=%b expected=0", halted); end
    checks++;
    if (tohostValue !== 32'h0) begin failures++; $display("[TB] FAIL tohost_cleared actual=%h expected=0", tohostValue); end
    bus.memoryAddress    = 32'h0;
    bus.memoryReadEnable = 1'b1;
    #1;
    checks++;
    if (bus.memoryReadData !== 32'h0000_A5A5) begin failures++; $display("[TB] FAIL write_in_reset_dropped actual=%h expected=0000a5a5", bus.memoryReadData); end
    bus.memoryReadEnable = 1'b0;
`ifdef RISCV_DMEM_ACCESS_COUNTERS_EN
    do_write(32'h40, 32'h1);
    do_write(32'h44, 32'h2);
    do_write(32'h48, 32'h3);
    do_read(32'h40, d);
    do_read(32'h44, d);
    do_read(MMIO_BASE + 32'hC, d);
    checks++;
    if (d !== 32'd2) begin failures++; $display("[TB] FAIL load_count actual=%0d expected=2", d); end
    do_read(MMIO_BASE + 32'h10, d);
    checks++;
    if (d !== 32'd3) begin failures++; $display("[TB] FAIL store_count actual=%0d expected=3", d); end
    checks++;
    if (accessFault !== 1'b0) begin failures++; $display("[TB] FAIL counters_no_fault actual=%b expected=0", accessFault); end
`else
    do_read(MMIO_BASE + 32'hC, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL loadcnt_unmapped_read actual=%h expected=0", d); end
    checks++;
    if (accessFault !== 1'b1) begin failures++; $display("[TB] FAIL loadcnt_unmapped_fault actual=%b expected=1", accessFault); end
    checks++;
    if (faultAddress !== MMIO_BASE + 32'hC) begin failures++; $display("[TB] FAIL loadcnt_fault_addr actual=%h expected=8000000c", faultAddress); end
`endif
  endtask

  initial begin
    checks                = 0;
    failures              = 0;
    rst                   = 1'b1;
    bus.memoryAddress     = 32'h0;
    bus.memoryReadEnable  = 1'b0;
    bus.memoryWriteEnable = 1'b0;
    bus.memoryWriteData   = 32'h0;
    $display("[TB] starting riscv_data_memory_mmio directed tests");
    test_reset();
    test_ram_rw();
    test_same_cycle();
    test_fault();
    test_cycle_counter();
    test_halt();
    test_access_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
